// File: rtl/float_divide_if.sv
// Operand/result handshake bundle for float_divide: operands flow in on
// in_valid/in_ready, the quotient flows out on out_valid/out_ready.
interface float_divide_if #(
  parameter int float_width = 16
);
  logic [float_width-1:0] float_a;
  logic [float_width-1:0] float_b;
  logic                   in_valid;
  logic                   in_ready;
  logic [float_width-1:0] res;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output float_a, float_b, in_valid, out_ready,
    input  in_ready, res, out_valid
  );

  modport slave (
    input  float_a, float_b, in_valid, out_ready,
    output in_ready, res, out_valid
  );
endinterface

// File: rtl/float_divide.sv
// Multi-cycle IEEE-754 divider: restoring mantissa division, one quotient bit per cycle.
// Define FLOAT_DIVIDE_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module float_divide #(
  parameter int float_width    = 16,
  parameter int exponent_width = 5,
  parameter int mantissa_width = 10
) (
  input  logic          clk,
  input  logic          rst,
  float_divide_if.slave bus
);
  localparam int BIAS    = (1 << (exponent_width - 1)) - 1;
  localparam int QW      = mantissa_width + 3;
  localparam int SW      = mantissa_width + 2;
  localparam int XW      = exponent_width + 2;
  localparam int CW      = $clog2(QW);
  localparam int EXP_ALL = (1 << exponent_width) - 1;
  localparam logic [exponent_width-1:0] EXP_MAX = '1;
  localparam logic signed [XW-1:0]      EXP_TOP = XW'(EXP_ALL);
`ifdef FLOAT_DIVIDE_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t                  r_state;
  logic [float_width-1:0]  r_res;
  logic [QW-1:0]           r_q;
  logic [SW-1:0]           r_rem;
  logic [mantissa_width:0] r_div;
  logic signed [XW-1:0]    r_exp;
  logic                    r_sign;
  logic [CW-1:0]           r_cnt;
  logic                    r_in_ready;
  logic                    r_out_valid;

  // Operand fields at the input port, used only on the accept edge.
  logic [exponent_width-1:0] w_ea, w_eb;
  logic [mantissa_width-1:0] w_fa, w_fb;
  logic                      w_sign_in;
  assign w_sign_in = bus.float_a[float_width-1] ^ bus.float_b[float_width-1];
  assign w_ea      = bus.float_a[float_width-2:mantissa_width];
  assign w_eb      = bus.float_b[float_width-2:mantissa_width];
  assign w_fa      = bus.float_a[mantissa_width-1:0];
  assign w_fb      = bus.float_b[mantissa_width-1:0];

  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special;
  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_a_inf   = (w_ea == EXP_MAX) && (w_fa == '0);
  assign w_b_inf   = (w_eb == EXP_MAX) && (w_fb == '0);
  assign w_a_nan   = (w_ea == EXP_MAX) && (w_fa != '0);
  assign w_b_nan   = (w_eb == EXP_MAX) && (w_fb != '0);
  assign w_special = w_a_zero || w_b_zero || (w_ea == EXP_MAX) || (w_eb == EXP_MAX);

  logic [float_width-1:0] w_special_res;
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_special_res = {w_sign_in, {(float_width-1){1'b0}}};
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
      w_special_res = {1'b0, EXP_MAX, 1'b1, {(mantissa_width-1){1'b0}}};
    else if (w_a_inf || w_b_zero)
      w_special_res = {w_sign_in, EXP_MAX, {mantissa_width{1'b0}}};
  end

  logic signed [XW-1:0] w_exp_diff;
  assign w_exp_diff = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + XW'(BIAS);

  // One restoring step: subtract the divisor when it fits, then shift.
  logic [SW:0]   w_sub;
  logic          w_ge;
  logic [SW-1:0] w_rem_next;
  assign w_sub      = {1'b0, r_rem} - {2'b00, r_div};
  assign w_ge       = ~w_sub[SW];
  assign w_rem_next = w_ge ? w_sub[SW-1:0] : r_rem;

  // Normalisation: the quotient lies in [2^(QW-2), 2^QW), so at most one bit of shift.
  logic                    w_top, w_guard, w_sticky, w_inc;
  logic [mantissa_width-1:0] w_mant;
  logic [mantissa_width:0]   w_mant_r;
  logic signed [XW-1:0]      w_exp_n, w_exp_f;
  logic [float_width-1:0]    w_norm_res;
  assign w_top    = r_q[QW-1];
  assign w_mant   = w_top ? r_q[QW-2:2] : r_q[QW-3:1];
  assign w_guard  = w_top ? r_q[1] : r_q[0];
  assign w_sticky = (w_top & r_q[0]) | (r_rem != '0);
  assign w_exp_n  = w_top ? r_exp : r_exp - XW'(1);
  assign w_inc    = ROUND_EN & w_guard & (w_sticky | w_mant[0]);
  assign w_mant_r = {1'b0, w_mant} + {{mantissa_width{1'b0}}, w_inc};
  assign w_exp_f  = w_exp_n + $signed({{(XW-1){1'b0}}, w_mant_r[mantissa_width]});

  always_comb begin
    w_norm_res = {r_sign, w_exp_f[exponent_width-1:0], w_mant_r[mantissa_width-1:0]};
    if (w_exp_f >= EXP_TOP)
      w_norm_res = {r_sign, EXP_MAX, {mantissa_width{1'b0}}};
    else if (w_exp_f[XW-1] || (w_exp_f == '0))
      w_norm_res = {r_sign, {(float_width-1){1'b0}}};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_res       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_in_ready <= 1'b0;
          if (w_special) begin
            r_res       <= w_special_res;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_rem   <= {1'b0, 1'b1, w_fa};
            r_div   <= {1'b1, w_fb};
            r_q     <= '0;
            r_exp   <= w_exp_diff;
            r_sign  <= w_sign_in;
            r_cnt   <= '0;
            r_state <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_q   <= {r_q[QW-2:0], w_ge};
          r_rem <= w_rem_next << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(QW - 1)) r_state <= NORM;
        end
        NORM: begin
          r_res       <= w_norm_res;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.res       = r_res;
endmodule

// File: doc/float_divide.md
FLOAT_DIVIDE -- requirements
Module: float_divide

Interface
REQ-001 Parameter float_width, default 16, total IEEE-754 binary16 word width.
REQ-002 Parameter exponent_width, default 5, exponent field width; bias = 2^(exponent_width-1)-1 = 15.
REQ-003 Parameter mantissa_width, default 10, stored fraction width (hidden 1 implied).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 float_a  input  float_width  dividend; sampled on accept.
REQ-007 float_b  input  float_width  divisor; sampled on accept.
REQ-008 in_valid  input  1  operands present.
REQ-009 in_ready  output  1  block can accept; accept = in_valid && in_ready at a rising edge.
REQ-010 res  output  float_width  quotient float_a / float_b.
REQ-011 out_valid  output  1  res valid.
REQ-012 out_ready  input  1  consumer takes res; retire = out_valid && out_ready at a rising edge.

Function
REQ-013 FSM states IDLE, DIVIDE, NORM, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE -> DIVIDE on accept of a finite nonzero pair; IDLE -> DONE on accept of a special-case pair (REQ-019), res loaded on that edge.
REQ-015 DIVIDE: restoring division, one quotient bit per cycle, 13 cycles, Q = floor(({1,ma} << 12) / {1,mb}), remainder kept; then NORM for 1 cycle; NORM -> DONE.
REQ-016 Latency: out_valid high after the 15th rising edge following the accept edge (normal path), after the 1st (special path).
REQ-017 Normalisation: if Q[12]=1, mantissa = Q[11:2], guard = Q[1], sticky = Q[0] | (rem != 0), exp = ea - eb + 15; else mantissa = Q[10:1], guard = Q[0], sticky = (rem != 0), exp = ea - eb + 14; exponent arithmetic in 7-bit signed.
REQ-018 Sign = float_a[15] ^ float_b[15] for every result, including zero and infinity; NaN result is canonical 16'h7E00.
REQ-019 Special cases: exponent field 0 = zero (subnormals flushed); any NaN input, 0/0, or inf/inf -> 16'h7E00; finite/0 -> signed inf; inf/finite -> signed inf; finite/inf -> signed zero; 0/nonzero-finite -> signed zero.
REQ-020 Final exp >= 31 (incl. after rounding carry) -> signed infinity {s,5'h1F,10'h0}; final exp <= 0 -> signed zero.
REQ-021 Rounding carry out of mantissa (all ones + 1) -> mantissa 0, exp + 1, then REQ-020 check.
REQ-022 DONE: res and out_valid held stable while out_ready = 0; on retire -> IDLE, in_ready high the following cycle; no accept on the retire edge.
REQ-023 Operand changes on float_a/float_b after accept do not affect the in-flight result.

Reset
REQ-024 rst high at a rising edge -> state IDLE, in_ready = 1, out_valid = 0, res = 0, quotient/remainder registers cleared.
REQ-025 rst in DIVIDE, NORM or DONE aborts the operation; no out_valid is produced for it.
REQ-026 rst has priority over accept and retire on the same edge.

Configuration
REQ-027 Macro FLOAT_DIVIDE_ROUND_EN defined: round-to-nearest-even, increment when guard && (sticky || mantissa[0]).
REQ-028 FLOAT_DIVIDE_ROUND_EN undefined: truncation, guard and sticky ignored; latency and special-case behaviour unchanged.

Verification
REQ-029 0x4000 / 0x3C00 accepted, out_ready = 1 -> res 0x4000, out_valid exactly 15 edges after accept, single-cycle pulse.
REQ-030 0x3C00 / 0x4200 -> 0x3555; 0xC000 / 0x4000 -> 0xBC00; 0x4200 / 0x4900 -> 0x34CD with FLOAT_DIVIDE_ROUND_EN, 0x34CC without.
REQ-031 Specials: 0x3C00/0x0000 -> 0x7C00; 0x0000/0x0000 -> 0x7E00; 0x7C00/0x7C00 -> 0x7E00; 0x3C00/0x7C00 -> 0x0000; each out_valid 1 edge after accept.
REQ-032 Range: 0x7BFF / 0x0400 -> 0x7C00; 0x0400 / 0x7BFF -> 0x0000.
REQ-033 Backpressure: out_ready = 0 for 5 cycles in DONE -> res and out_valid stable, in_ready = 0, new in_valid ignored; out_ready = 1 -> retire, in_ready = 1 next cycle.
REQ-034 rst asserted on 6th DIVIDE cycle -> next cycle in IDLE, in_ready = 1, out_valid = 0, res = 0; following 0x4000/0x3C00 completes normally.
